// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern engine: display modes,
// bounce direction and a one-hot helper.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_ROTL   = 2'b00,
        MODE_ROTR   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_COUNT  = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Widest LED bank the one-hot helper can describe; callers keep the low bits.
    localparam int LED_MAX_WIDTH = 256;

    // Returns a vector with only bit 'pos' set.
    function automatic logic [LED_MAX_WIDTH-1:0] onehot(input int unsigned pos);
        logic [LED_MAX_WIDTH-1:0] one;
        one = {{(LED_MAX_WIDTH-1){1'b0}}, 1'b1};
        return one << pos;
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// Free-running prescaler producing a single-cycle enable every 2^DIV_FAST
// or 2^DIV_SLOW clocks. The counter is never cleared on a speed change,
// so switching speed cannot produce an extra or shortened pulse.
module led_prescaler #(
    parameter int DIV_FAST = 21,
    parameter int DIV_SLOW = 23
) (
    input  logic CLK,
    input  logic RESET,
    input  logic SPEED,
    output logic tick_en
);

    logic [DIV_SLOW-1:0] presc_q;
    logic [DIV_SLOW-1:0] presc_d;
    logic                fast_all;
    logic                slow_all;

    assign presc_d  = presc_q + 1'b1;
    assign fast_all = &presc_q[DIV_FAST-1:0];
    assign slow_all = &presc_q;
    assign tick_en  = SPEED ? slow_all : fast_all;

    // Wrapping up-counter shared by both speeds.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern sequencer: rotate-left, rotate-right, bounce and binary count,
// advancing once per prescaler tick. LED and TICK are registered.
// Optional feature macro LED_PWM_EN adds a BRIGHT input that dims lit LEDs
// with a 3-bit PWM (duty = (BRIGHT+1)/8).
module led_pattern_engine
    import led_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DIV_FAST   = 21,
    parameter int DIV_SLOW   = 23,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [1:0]       MODE,
    input  logic             SPEED,
`ifdef LED_PWM_EN
    input  logic [2:0]       BRIGHT,
`endif
    output logic [WIDTH-1:0] LED,
    output logic             TICK
);

    localparam int               PW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [PW-1:0]    POS_MAX   = PW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] POL       = {WIDTH{ACTIVE_LOW}};
    localparam logic [WIDTH-1:0] RESET_LED = WIDTH'(1) ^ POL;

    logic             tick_en;
    mode_e            mode_q, mode_d;
    dir_e             dir_q, dir_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] lit_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic             tick_q;

    led_prescaler #(
        .DIV_FAST (DIV_FAST),
        .DIV_SLOW (DIV_SLOW)
    ) u_prescaler (
        .CLK     (CLK),
        .RESET   (RESET),
        .SPEED   (SPEED),
        .tick_en (tick_en)
    );

    // Next pattern state: a mode change restarts the pattern instead of advancing.
    always_comb begin
        mode_d = mode_q;
        dir_d  = dir_q;
        pos_d  = pos_q;
        cnt_d  = cnt_q;
        if (tick_en) begin
            if (MODE != mode_q) begin
                mode_d = mode_e'(MODE);
                dir_d  = DIR_UP;
                pos_d  = '0;
                cnt_d  = '0;
            end else begin
                unique case (mode_q)
                    MODE_ROTL:   pos_d = (pos_q == POS_MAX) ? '0 : pos_q + 1'b1;
                    MODE_ROTR:   pos_d = (pos_q == '0) ? POS_MAX : pos_q - 1'b1;
                    MODE_BOUNCE: begin
                        if (dir_q == DIR_UP) begin
                            if (pos_q == POS_MAX) begin
                                dir_d = DIR_DOWN;
                                pos_d = POS_MAX - 1'b1;
                            end else begin
                                pos_d = pos_q + 1'b1;
                            end
                        end else begin
                            if (pos_q == '0) begin
                                dir_d = DIR_UP;
                                pos_d = PW'(1);
                            end else begin
                                pos_d = pos_q - 1'b1;
                            end
                        end
                    end
                    default:     cnt_d = cnt_q + 1'b1;
                endcase
            end
        end
        lit_d = (mode_d == MODE_COUNT) ? cnt_d : WIDTH'(onehot(32'(pos_d)));
    end

`ifdef LED_PWM_EN
    logic [2:0] pwm_q, pwm_d;
    logic       pwm_on;

    assign pwm_d  = pwm_q + 1'b1;
    assign pwm_on = (pwm_d <= BRIGHT);
    assign led_d  = (lit_d & {WIDTH{pwm_on}}) ^ POL;

    // PWM phase counter, advancing every clock.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_d;
        end
    end
`else
    assign led_d = lit_d ^ POL;
`endif

    // Pattern state, registered LED drive and tick strobe.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mode_q <= MODE_ROTL;
            dir_q  <= DIR_UP;
            pos_q  <= '0;
            cnt_q  <= '0;
            led_q  <= RESET_LED;
            tick_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            dir_q  <= dir_d;
            pos_q  <= pos_d;
            cnt_q  <= cnt_d;
            led_q  <= led_d;
            tick_q <= tick_en;
        end
    end

    assign LED  = led_q;
    assign TICK = tick_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine (WIDTH=8, DIV_FAST=2, DIV_SLOW=4,
// ACTIVE_LOW=1). A tick-level reference model derives the expected pattern
// from the number of ticks since the last mode change.
module tb_led_pattern_engine;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [1:0] MODE = 2'b00;
    logic       SPEED = 1'b0;
    logic [7:0] LED;
    logic       TICK;
`ifdef LED_PWM_EN
    logic [2:0] BRIGHT = 3'd7;
`endif

    led_pattern_engine #(
        .WIDTH      (8),
        .DIV_FAST   (2),
        .DIV_SLOW   (4),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .MODE   (MODE),
        .SPEED  (SPEED),
`ifdef LED_PWM_EN
        .BRIGHT (BRIGHT),
`endif
        .LED    (LED),
        .TICK   (TICK)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int         pc;        // prescaler count since reset
    int         k;         // ticks since last mode change
    logic [1:0] mode_m;
    bit         exp_tick;

    typedef struct {
        logic [1:0] mode;
        int         ticks;
        logic [7:0] exp_led;
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_lit();
        logic [7:0] one;
        int p;
        one = 8'd1;
        case (mode_m)
            2'd0: p = k % 8;
            2'd1: p = (8 - (k % 8)) % 8;
            2'd2: begin
                p = k % 14;
                if (p > 7) p = 14 - p;
            end
            default: return 8'(k % 256);
        endcase
        return one << p;
    endfunction

    task automatic model_reset();
        pc       = 0;
        k        = 0;
        mode_m   = 2'd0;
        exp_tick = 1'b0;
    endtask

    // One clock: predict, clock, compare LED and TICK
    task automatic cycle();
        int  m;
        bit  tk;
        m  = SPEED ? 15 : 3;
        tk = ((pc & m) == m);
        @(posedge CLK);
        #1;
        if (RESET) begin
            model_reset();
        end else begin
            pc = (pc + 1) & 15;
            if (tk) begin
                if (MODE != mode_m) begin
                    mode_m = MODE;
                    k      = 0;
                end else begin
                    k++;
                end
            end
            exp_tick = tk;
        end
        chk("led", {24'd0, LED}, {24'd0, ~exp_lit()});
        chk("tick", {31'd0, TICK}, {31'd0, exp_tick});
    endtask

    task automatic run_ticks(input int n, output int cyc);
        int got;
        got = 0;
        cyc = 0;
        while (got < n && cyc < n * 20 + 20) begin
            cycle();
            cyc++;
            if (exp_tick) got++;
        end
        if (got < n) begin
            checks++;
            failures++;
            $display("FAIL tick_budget: got %0d ticks expected %0d", got, n);
        end
    endtask

    task automatic assert_reset();
        RESET = 1'b1;
        #1;
        model_reset();
        chk("async_rst_led", {24'd0, LED}, 32'h0000_00FE);
        chk("async_rst_tick", {31'd0, TICK}, 32'd0);
    endtask

    // Cycles between the next two DUT TICK pulses
    task automatic measure_gap(output int gap);
        int t0;
        t0  = -1;
        gap = -1;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (TICK) begin
                if (t0 < 0) t0 = i;
                else begin
                    gap = i - t0;
                    break;
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int gap;

        tbl[0]  = '{2'd0, 1,   8'hFD};
        tbl[1]  = '{2'd0, 6,   8'h7F};
        tbl[2]  = '{2'd0, 1,   8'hFE};
        tbl[3]  = '{2'd1, 1,   8'hFE};
        tbl[4]  = '{2'd1, 1,   8'h7F};
        tbl[5]  = '{2'd1, 1,   8'hBF};
        tbl[6]  = '{2'd2, 1,   8'hFE};
        tbl[7]  = '{2'd2, 7,   8'h7F};
        tbl[8]  = '{2'd2, 1,   8'hBF};
        tbl[9]  = '{2'd2, 6,   8'hFE};
        tbl[10] = '{2'd2, 1,   8'hFD};
        tbl[11] = '{2'd3, 1,   8'hFF};
        tbl[12] = '{2'd3, 5,   8'hFA};
        tbl[13] = '{2'd3, 251, 8'hFF};
        tbl[14] = '{2'd3, 1,   8'hFE};
        tbl[15] = '{2'd0, 1,   8'hFE};

        // Reset state
        #1;
        RESET = 1'b1;
        #1;
        model_reset();
        chk("reset_led", {24'd0, LED}, 32'h0000_00FE);
        chk("reset_tick", {31'd0, TICK}, 32'd0);
        cycle();
        cycle();
        RESET = 1'b0;

        // Table-driven pattern sequence
        for (int i = 0; i < 16; i++) begin
            MODE = tbl[i].mode;
            run_ticks(tbl[i].ticks, cyc);
            chk($sformatf("vec%0d_led", i), {24'd0, LED}, {24'd0, tbl[i].exp_led});
            $display("vec %0d mode=%0d ticks=%0d led=%h", i, tbl[i].mode, tbl[i].ticks, LED);
        end

        // Fast tick spacing
        measure_gap(gap);
        chk("fast_gap", gap, 32'd4);

        // Speed change mid-count: next tick at prescaler low nibble = F, then 16-cycle spacing
        SPEED = 1'b1;
        measure_gap(gap);
        chk("slow_gap", gap, 32'd16);
        SPEED = 1'b0;
        run_ticks(1, cyc);

        // Reset between ticks while bouncing downward
        MODE = 2'd2;
        run_ticks(1, cyc);
        run_ticks(8, cyc);
        chk("bounce_down_led", {24'd0, LED}, 32'h0000_00BF);
        #2;
        assert_reset();
        MODE = 2'd0;
        cycle();
        cycle();
        RESET = 1'b0;
        run_ticks(1, cyc);
        chk("post_reset_latency", cyc, 32'd4);
        chk("post_reset_led", {24'd0, LED}, 32'h0000_00FD);
        $display("reset-in-bounce: first tick after %0d cycles led=%h", cyc, LED);

        // Randomized operation against the reference model
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 29) == 0) MODE = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) SPEED = ~SPEED;
            if ($urandom_range(0, 399) == 0) begin
                assert_reset();
                cycle();
                RESET = 1'b0;
            end
            cycle();
        end
        $display("random phase done: mode=%0d speed=%0d led=%h", MODE, SPEED, LED);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
